// File: rtl/window_feeder.sv
// window_feeder: captures a WIN x WIN (optionally subsampled) window from the pixel stream
// into a buffer, then streams it out in raster order over valid/ready.
module window_feeder #(
    parameter int WIN     = 20,
    parameter int FRAME_W = 640,
    parameter int FRAME_H = 480
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       PIX_VALID,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic [7:0] VGA_R_in,
    input  logic [7:0] VGA_G_in,
    input  logic [7:0] VGA_B_in,
    input  logic       START,
    input  logic [9:0] WIN_X,
    input  logic [9:0] WIN_Y,
    input  logic [1:0] SCALE,
    input  logic       CLS_READY,
    output logic [8:0] ADDR,
    output logic [7:0] VGA_R_out,
    output logic [7:0] VGA_G_out,
    output logic [7:0] VGA_B_out,
    output logic       OUT_VALID,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERR
);
    localparam int N = WIN * WIN;
    typedef enum logic [1:0] {IDLE, ARM, CAPTURE, STREAM} state_t;
    state_t r_state, w_next;
    logic [9:0]  r_wx, r_wy;
    logic [1:0]  r_s;
    logic [11:0] w_req_span;
    logic        w_bad;
    logic [10:0] w_dx, w_dy, w_span, w_mask;
    logic        w_in, w_sof, w_take, w_wdone;
    logic [8:0]  w_idx, r_cnt, r_wr_addr, r_a1, w_rd_addr, w_mem_addr, r_addr;
    logic [23:0] r_wr_data, r_rd, r_rgb;
    logic [23:0] r_mem [N];
    logic        r_wr_en, r_v1, r_ov, r_err, r_done, w_adv, w_last, w_fetch;
    logic [9:0]  r_ra;
    assign w_req_span = 12'(WIN) << SCALE;
    assign w_bad = ({2'b0, WIN_X} + w_req_span > 12'(FRAME_W)) ||
                   ({2'b0, WIN_Y} + w_req_span > 12'(FRAME_H));
    // A negative difference wraps above 1023, so the unsigned span compare rejects it too
    assign w_dx = {1'b0, DrawX} - {1'b0, r_wx};
    assign w_dy = {1'b0, DrawY} - {1'b0, r_wy};
    assign w_span = 11'(WIN) << r_s;
    assign w_mask = (11'd1 << r_s) - 11'd1;
    assign w_in = w_dx < w_span && w_dy < w_span && (w_dx & w_mask) == 11'd0 && (w_dy & w_mask) == 11'd0;
    assign w_idx = 9'((w_dy >> r_s) * 11'(WIN) + (w_dx >> r_s));
    assign w_sof = PIX_VALID && DrawX == 10'd0 && DrawY == 10'd0;
    assign w_wdone = r_wr_en && r_cnt == 9'(N - 1);
    assign w_take = PIX_VALID && w_in && ((r_state == ARM && w_sof) || (r_state == CAPTURE && !w_wdone));
    // Stalls re-read the stage-1 address so the RAM output keeps its word
    assign w_adv = !r_ov || CLS_READY;
    assign w_last = r_state == STREAM && r_ov && CLS_READY && r_addr == 9'(N - 1);
    assign w_fetch = r_ra < 10'(N);
    assign w_rd_addr = w_adv ? r_ra[8:0] : r_a1;
    assign w_mem_addr = r_wr_en ? r_wr_addr : w_rd_addr;
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (START && !w_bad) w_next = ARM;
            ARM:     if (w_sof) w_next = CAPTURE;
            CAPTURE: if (w_wdone) w_next = STREAM;
            default: if (w_last) w_next = IDLE;
        endcase
    end
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= IDLE;
            r_err   <= 1'b0;
            r_done  <= 1'b0;
            r_wr_en <= 1'b0;
            r_cnt   <= 9'd0;
            r_ra    <= 10'd0;
            r_a1    <= 9'd0;
            r_v1    <= 1'b0;
            r_ov    <= 1'b0;
            r_addr  <= 9'd0;
            r_rgb   <= 24'd0;
        end else begin
            r_state <= w_next;
            r_err   <= r_state == IDLE && START && w_bad;
            r_done  <= w_last;
            r_wr_en <= w_take;
            r_cnt   <= (r_state != CAPTURE || w_sof) ? 9'd0 : r_cnt + 9'(r_wr_en);
            if (r_state != STREAM) begin
                r_ra <= 10'd0;
                r_a1 <= 9'd0;
                r_v1 <= 1'b0;
            end else if (w_adv) begin
                r_ov   <= r_v1;
                r_addr <= w_last ? 9'd0 : r_a1;
                r_rgb  <= w_last ? 24'd0 : r_rd;
                r_v1   <= w_fetch;
                r_a1   <= r_ra[8:0];
                r_ra   <= r_ra + 10'(w_fetch);
            end
        end
    end
    always_ff @(posedge CLK) begin
        if (r_state == IDLE && START) begin
            r_wx <= WIN_X;
            r_wy <= WIN_Y;
            r_s  <= SCALE;
        end
        r_wr_addr <= w_idx;
        r_wr_data <= {VGA_R_in, VGA_G_in, VGA_B_in};
    end
    always_ff @(posedge CLK) begin
        if (r_wr_en) r_mem[r_wr_addr] <= r_wr_data;
        r_rd <= r_mem[w_mem_addr];
    end
    assign ADDR = r_addr;
    assign {VGA_R_out, VGA_G_out, VGA_B_out} = r_rgb;
    assign OUT_VALID = r_ov;
    assign BUSY = r_state != IDLE;
    assign DONE = r_done;
    assign ERR = r_err;
endmodule

// File: tb/tb_window_feeder.sv
// tb_window_feeder: directed stimulus with a window-geometry model checked on every output cycle.
module tb_window_feeder;
    logic CLK = 0, RESET = 1, PIX_VALID = 0, START = 0, CLS_READY = 1;
    logic [9:0] DrawX = 0, DrawY = 0, WIN_X = 0, WIN_Y = 0;
    logic [1:0] SCALE = 0;
    logic [7:0] VGA_R_in = 0, VGA_G_in = 0, VGA_B_in = 0;
    logic [8:0] ADDR;
    logic [7:0] VGA_R_out, VGA_G_out, VGA_B_out;
    logic OUT_VALID, BUSY, DONE, ERR;
    logic [23:0] dout;
    int checks = 0, failures = 0;
    int n = 0, done_cnt = 0, err_cnt = 0;
    bit exp_on = 0, no_bubble = 0;
    int m_wx = 0, m_wy = 0, m_s = 0;
    logic [7:0] m_b = 0;
    logic [23:0] obs [400];
    logic prev_hold = 0;
    logic [8:0] prev_addr = 0;
    logic [23:0] prev_data = 0;
    logic [3:0] pat = 4'b1001;
    assign dout = {VGA_R_out, VGA_G_out, VGA_B_out};

    window_feeder dut (
        .CLK(CLK), .RESET(RESET), .PIX_VALID(PIX_VALID), .DrawX(DrawX), .DrawY(DrawY),
        .VGA_R_in(VGA_R_in), .VGA_G_in(VGA_G_in), .VGA_B_in(VGA_B_in),
        .START(START), .WIN_X(WIN_X), .WIN_Y(WIN_Y), .SCALE(SCALE), .CLS_READY(CLS_READY),
        .ADDR(ADDR), .VGA_R_out(VGA_R_out), .VGA_G_out(VGA_G_out), .VGA_B_out(VGA_B_out),
        .OUT_VALID(OUT_VALID), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, expv, expv);
        end
    endtask

    // Word k of the window is the frame pixel at (col, row) scaled by 2^s from the origin
    function automatic int exp_word(input int k);
        int x = m_wx + ((k % 20) << m_s);
        int y = m_wy + ((k / 20) << m_s);
        return ((x & 255) << 16) | ((y & 255) << 8) | int'(m_b);
    endfunction

    always @(negedge CLK) begin
        if (!RESET) begin
            if (prev_hold) begin
                chk("hold_valid", int'(OUT_VALID), 1);
                chk("hold_addr", int'(ADDR), int'(prev_addr));
                chk("hold_data", int'(dout), int'(prev_data));
            end
            chk("valid_allowed", int'(OUT_VALID && !exp_on), 0);
            if (OUT_VALID && exp_on) begin
                chk("addr", int'(ADDR), n);
                chk("data", int'(dout), exp_word(n));
                if (CLS_READY) begin
                    if (n < 400) obs[n] = dout;
                    n++;
                end
            end
            if (exp_on && no_bubble && n > 0 && n < 400) chk("no_bubble", int'(OUT_VALID), 1);
            if (DONE) begin
                done_cnt++;
                chk("done_words", n, 400);
                chk("done_valid", int'(OUT_VALID), 0);
                chk("done_addr", int'(ADDR), 0);
                chk("done_busy", int'(BUSY), 0);
            end
            if (ERR) err_cnt++;
            prev_hold = OUT_VALID && !CLS_READY;
            prev_addr = ADDR;
            prev_data = dout;
        end else prev_hold = 0;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pix(input int x, input int y, input logic [7:0] b);
        PIX_VALID = 1;
        DrawX = 10'(x);
        DrawY = 10'(y);
        VGA_R_in = 8'(x);
        VGA_G_in = 8'(y);
        VGA_B_in = b;
        tick();
        PIX_VALID = 0;
    endtask

    task automatic frame(input int x0, input int x1, input int y0, input int y1, input logic [7:0] b);
        pix(0, 0, b);
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++)
                if (x != 0 || y != 0) pix(x, y, b);
    endtask

    task automatic window(input int x, input int y, input int s, input logic [7:0] b);
        int span = 20 << s;
        frame((x > 2) ? x - 2 : 0, (x + span + 1 > 639) ? 639 : x + span + 1,
              (y > 2) ? y - 2 : 0, y + span - 1, b);
    endtask

    task automatic do_start(input int x, input int y, input int s);
        WIN_X = 10'(x);
        WIN_Y = 10'(y);
        SCALE = 2'(s);
        START = 1;
        tick();
        START = 0;
    endtask

    task automatic arm_model(input int x, input int y, input int s, input logic [7:0] b);
        m_wx = x;
        m_wy = y;
        m_s = s;
        m_b = b;
        n = 0;
        exp_on = 1;
    endtask

    task automatic stream(input int mode);
        int c = 0;
        int d0 = done_cnt;
        while (done_cnt == d0 && c < 3000) begin
            CLS_READY = (mode != 0) ? pat[c % 4] : 1'b1;
            tick();
            c++;
        end
        chk("done_before_timeout", int'(done_cnt != d0), 1);
        CLS_READY = 1;
        repeat (3) tick();
        chk("single_done", done_cnt, d0 + 1);
        chk("idle_after_done", int'(BUSY), 0);
        exp_on = 0;
        no_bubble = 0;
    endtask

    initial begin
        int c;
        int e0;
        repeat (2) tick();
        chk("rst_addr", int'(ADDR), 0);
        chk("rst_data", int'(dout), 0);
        chk("rst_valid", int'(OUT_VALID), 0);
        chk("rst_busy", int'(BUSY), 0);
        chk("rst_done", int'(DONE), 0);
        chk("rst_err", int'(ERR), 0);
        RESET = 0;
        tick();
        // basic window
        arm_model(100, 50, 0, 8'h5A);
        no_bubble = 1;
        do_start(100, 50, 0);
        chk("busy_after_start", int'(BUSY), 1);
        chk("no_err_on_accept", int'(ERR), 0);
        window(100, 50, 0, 8'h5A);
        stream(0);
        chk("basic_w0", int'(obs[0]), 24'h64325A);
        chk("basic_w21", int'(obs[21]), 24'h65335A);
        chk("basic_w399", int'(obs[399]), 24'h77455A);
        // subsampled window
        arm_model(0, 0, 2, 8'h77);
        no_bubble = 1;
        do_start(0, 0, 2);
        window(0, 0, 2, 8'h77);
        stream(0);
        chk("sub_w21", int'(obs[21]), 24'h040477);
        chk("sub_w399", int'(obs[399]), 24'h4C4C77);
        // backpressure, held off during capture as well
        arm_model(37, 21, 1, 8'hC3);
        CLS_READY = 0;
        do_start(37, 21, 1);
        window(37, 21, 1, 8'hC3);
        stream(1);
        chk("bp_w41", int'(obs[41]), 24'h2719C3);
        // rejects and edge-of-frame accept
        e0 = err_cnt;
        do_start(630, 0, 0);
        chk("rej_err", int'(ERR), 1);
        chk("rej_busy", int'(BUSY), 0);
        tick();
        chk("rej_err_pulse", int'(ERR), 0);
        do_start(0, 401, 2);
        chk("rej_scaled_err", int'(ERR), 1);
        chk("rej_scaled_busy", int'(BUSY), 0);
        repeat (20) tick();
        chk("rej_no_valid", int'(OUT_VALID), 0);
        chk("rej_err_count", err_cnt, e0 + 2);
        arm_model(620, 460, 0, 8'h9C);
        do_start(620, 460, 0);
        chk("edge_accept_busy", int'(BUSY), 1);
        chk("edge_accept_err", int'(ERR), 0);
        do_start(630, 0, 2);
        chk("busy_start_err", int'(ERR), 0);
        chk("busy_start_busy", int'(BUSY), 1);
        no_bubble = 1;
        window(620, 460, 0, 8'h9C);
        stream(0);
        chk("edge_w0", int'(obs[0]), 24'h6CCC9C);
        chk("busy_start_no_err", err_cnt, e0 + 2);
        // reset in the middle of streaming
        arm_model(100, 50, 0, 8'h5A);
        do_start(100, 50, 0);
        window(100, 50, 0, 8'h5A);
        c = 0;
        while (!(OUT_VALID && ADDR == 9'd137) && c < 3000) begin
            tick();
            c++;
        end
        chk("reached_137", int'(ADDR), 137);
        exp_on = 0;
        e0 = done_cnt;
        RESET = 1;
        tick();
        RESET = 0;
        chk("mid_rst_addr", int'(ADDR), 0);
        chk("mid_rst_data", int'(dout), 0);
        chk("mid_rst_valid", int'(OUT_VALID), 0);
        chk("mid_rst_busy", int'(BUSY), 0);
        chk("mid_rst_done", int'(DONE), 0);
        chk("mid_rst_err", int'(ERR), 0);
        tick();
        chk("mid_rst_no_done", done_cnt, e0);
        arm_model(100, 50, 0, 8'h6E);
        no_bubble = 1;
        do_start(100, 50, 0);
        window(100, 50, 0, 8'h6E);
        stream(0);
        chk("after_rst_w137", int'(obs[137]), 24'h75386E);
        // frame restarts after 200 captures
        arm_model(100, 50, 0, 8'h33);
        do_start(100, 50, 0);
        frame(98, 121, 50, 59, 8'h11);
        window(100, 50, 0, 8'h33);
        stream(0);
        chk("restart_w0", int'(obs[0]), 24'h643233);
        chk("restart_w250", int'(obs[250]), 24'h6E3E33);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/window_feeder.md
# window_feeder

Captures one 20×20 RGB detection window from the live VGA pixel stream into an internal 400-entry buffer, then streams it to the classifier as raster-ordered (ADDR, R, G, B) words over a valid/ready handshake. It sits directly upstream of the classifier stage. It converts arbitrary-origin, optionally subsampled frame regions into the fixed 0..399 address sequence the classifier consumes.

## Interface
Parameters:
- WIN, 20, window side in samples (buffer holds WIN*WIN words).
- FRAME_W, 640, active frame width in pixels.
- FRAME_H, 480, active frame height in pixels.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- PIX_VALID  in  1  strobe: DrawX/DrawY/VGA_*_in describe a valid active pixel this cycle.
- DrawX  in  10  column of current pixel.
- DrawY  in  10  row of current pixel.
- VGA_R_in, VGA_G_in, VGA_B_in  in  8 each  pixel colour.
- START  in  1  one-cycle request to capture a window from the next frame.
- WIN_X, WIN_Y  in  10 each  window top-left in frame pixels; sampled with START.
- SCALE  in  2  subsample shift s; window spans WIN<<s pixels per side; sampled with START.
- CLS_READY  in  1  classifier accepts a word this cycle.
- ADDR  out  9  buffer index of current output word (row*WIN + col).
- VGA_R_out, VGA_G_out, VGA_B_out  out  8 each  output pixel colour.
- OUT_VALID  out  1  output word valid.
- BUSY  out  1  high in any state except IDLE.
- DONE  out  1  one-cycle pulse after the final word transfers.
- ERR  out  1  one-cycle pulse when a START is rejected.

## Operation
- States: IDLE, ARM, CAPTURE, STREAM.
- IDLE: on START, latch WIN_X/WIN_Y/SCALE. If WIN_X+(WIN<<SCALE) > FRAME_W or WIN_Y+(WIN<<SCALE) > FRAME_H, pulse ERR and stay in IDLE. Otherwise go to ARM.
- START in any non-IDLE state is ignored: no ERR, latched parameters unchanged.
- ARM: wait for PIX_VALID with DrawX==0 and DrawY==0, then go to CAPTURE. That pixel is also evaluated for capture in the same cycle.
- CAPTURE: a pixel is taken when all of the following hold:
  - PIX_VALID is high;
  - dx=DrawX−WIN_X and dy=DrawY−WIN_Y both lie in [0, WIN<<s);
  - the low s bits of dx and of dy are zero.
- A taken pixel is written to buf[(dy>>s)*WIN + (dx>>s)]. A capture counter increments per write. When it reaches WIN*WIN (400), go to STREAM.
- Differences are computed at 11 bits signed; negative means outside the window.
- Frame restart during CAPTURE (PIX_VALID at 0,0 before 400 writes): reset the capture counter and continue capturing from that frame.
- STREAM: present buf[0..399] in order. A transfer occurs on a cycle with OUT_VALID && CLS_READY. ADDR advances by 1 per transfer.
- While OUT_VALID is high and CLS_READY is low, ADDR and data are held stable.
- After the transfer at ADDR==399: OUT_VALID→0, ADDR→0, DONE pulses, state→IDLE.
- Pixel input is ignored outside ARM/CAPTURE.
- Consumers must qualify ADDR/data with OUT_VALID.
- The buffer is single-port synchronous RAM with 1-cycle read latency. It is not cleared by RESET.

## Timing
- RESET (any state, including mid-CAPTURE or mid-STREAM) → next cycle: IDLE, with ADDR=0, VGA_*_out=0, OUT_VALID=0, BUSY=0, DONE=0, ERR=0.
- START→BUSY: BUSY is high the cycle after START is accepted. ERR pulses the cycle after a rejected START.
- Capture write occurs in the cycle after the qualifying pixel. STREAM is entered the cycle after the 400th write.
- First OUT_VALID: 2 cycles after entering STREAM (read prefetch).
- With CLS_READY held high, 400 transfers occur on 400 consecutive cycles, with no bubbles. A stall of any length is followed by the next word on the cycle after CLS_READY returns.
- DONE is high the cycle after the last transfer. BUSY drops the same cycle.

## Test plan
- Basic: START with WIN_X=100, WIN_Y=50, SCALE=0. Drive a full frame with R=DrawX[7:0], G=DrawY[7:0], B=0x5A, CLS_READY=1. Expect ADDR 0..399 on consecutive cycles; word k has R=100+k%20 and G=50+k/20; then DONE pulses once.
- Subsample: SCALE=2, WIN_X=0, WIN_Y=0. Expect word k to be pixel (4*(k%20), 4*(k/20)), e.g. k=21 → (4,4).
- Backpressure: toggle CLS_READY 1,0,0,1 repeatedly. Expect ADDR/data to hold during the low cycles, no word skipped or duplicated, and exactly 400 transfers.
- Reject: START with WIN_X=630, SCALE=0. Expect ERR for one cycle, BUSY=0, and no OUT_VALID. START issued while BUSY expects no effect on the output sequence.
- Reset mid-STREAM: assert RESET at ADDR=137. Expect all outputs 0 and BUSY=0 on the next cycle. A new START then produces a complete 0..399 sequence.
- Frame restart: inject (0,0) after 200 captures. Expect the counter to restart, the output to come entirely from the second frame, and exactly 400 words.
